// File: rtl/bin_to_bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_pkg
// Shared constants and types for the sequential binary-to-BCD converter and
// the downstream four-digit seven-segment multiplexer (whose packed BCD `num`
// input width is 4*DIGITS_DEF).
// Contents:
//   BIN_W_DEF   - default binary input width
//   DIGITS_DEF  - default number of BCD digits
//   MAX_VAL_DEF - largest representable value; larger inputs saturate
//   CNT_W_DEF   - bit-counter width, clog2(BIN_W_DEF)
//   state_t     - converter FSM encoding (IDLE=0, SHIFT=1)
// -----------------------------------------------------------------------------
package bin_to_bcd_seq_pkg;

  localparam int BIN_W_DEF   = 14;
  localparam int DIGITS_DEF  = 4;
  localparam int MAX_VAL_DEF = 9999;
  localparam int CNT_W_DEF   = $clog2(BIN_W_DEF);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit corrector: a BCD digit that is 5 or more
// gets 3 added so that the following left shift carries correctly into the
// next decimal digit.
// Ports:
//   d_i [3:0] - digit before correction
//   d_o [3:0] - corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Digits reaching here are at most 9, so the sum never exceeds 12 and
  // stays inside the 4-bit digit.
  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) begin
      d_o = d_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock)
// feeding the seven-segment multiplexer. A start accepted in IDLE captures a
// saturated copy of bin; BIN_W cycles later the finished result is written to
// bcd and done pulses for one cycle. bcd/ovf hold between conversions so the
// display never shows partial accumulator values.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous reset, active-low
//   bin   - binary value, sampled only on an accepted start
//   start - conversion request, level-sampled, ignored while busy
//   busy  - conversion in progress
//   done  - one-cycle pulse when bcd has been updated
//   bcd   - packed BCD result, digit 0 in [3:0]
//   ovf   - last converted input exceeded MAX_VAL
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W   = BIN_W_DEF,
  parameter int DIGITS  = DIGITS_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);

  // Clamp to MAX_VAL; this keeps every digit <= 9 so add-3 never carries
  // across a digit boundary.
  function automatic logic [BIN_W-1:0] sat_bin(input logic [BIN_W-1:0] x);
    return (x > MAX_BIN) ? MAX_BIN : x;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [BIN_W-1:0]   binr_q, binr_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               ovfp_q, ovfp_d;
  logic               done_q, done_d;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;

  // ---- correction stage: add 3 to each digit >= 5 ----
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[4*g +: 4]),
      .d_o (acc_adj[4*g +: 4])
    );
  end

  // ---- shift stage: {acc, bin_reg} << 1 ----
  assign acc_shift = {acc_adj[ACC_W-2:0], binr_q[BIN_W-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    binr_d  = binr_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    ovfp_d  = ovfp_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          acc_d   = '0;
          binr_d  = sat_bin(bin);
          ovfp_d  = (bin > MAX_BIN);
        end
      end
      S_SHIFT: begin
        acc_d  = acc_shift;
        binr_d = {binr_q[BIN_W-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        // Last bit: publish the finished result directly from the shifter.
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          bcd_d   = acc_shift;
          ovf_d   = ovfp_q;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---- register stage ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      binr_q  <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      ovfp_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      binr_q  <= binr_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      ovfp_q  <= ovfp_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic [13:0] bin;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  // Expected {ovf, bcd} for each accepted conversion, in order.
  logic [16:0] exp_q[$];
  logic        done_prev;

  bin_to_bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .bin   (bin),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: saturate, then split into decimal digits arithmetically.
  function automatic logic [16:0] ref_model(input int v);
    int s;
    logic [15:0] r;
    s = (v > 9999) ? 9999 : v;
    r[3:0]   = 4'(s % 10);
    r[7:4]   = 4'((s / 10) % 10);
    r[11:8]  = 4'((s / 100) % 10);
    r[15:12] = 4'((s / 1000) % 10);
    return {(v > 9999), r};
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done pulse pops one expectation.
  initial done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("bcd", int'(bcd), int'(e[15:0]));
        check("ovf", int'(ovf), int'(e[16]));
      end
      check("done_width", int'(done_prev), 0);
    end
    done_prev = done;
  end

  // Start one conversion and wait for busy to drop; returns busy cycle count.
  task automatic run_conv(input int v, output int nbusy);
    bin   = 14'(v);
    start = 1'b1;
    tick;
    exp_q.push_back(ref_model(v));
    start = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 40) begin
      nbusy++;
      tick;
    end
  endtask

  initial begin
    int nb;
    rst   = 1'b0;
    bin   = '0;
    start = 1'b0;
    tick;
    tick;
    check("rst_bcd",  int'(bcd),  0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ovf",  int'(ovf),  0);
    rst = 1'b1;
    tick;

    // Zero, busy length and done timing.
    run_conv(0, nb);
    check("busy_cycles_0", nb, 14);
    check("done_after_busy", int'(done), 1);
    tick;
    check("done_one_cycle", int'(done), 0);

    // 1234 and hold.
    run_conv(1234, nb);
    check("busy_cycles_1234", nb, 14);
    repeat (20) tick;
    check("hold_bcd", int'(bcd), 16'h1234);
    check("hold_busy", int'(busy), 0);

    // Boundary values and saturation.
    run_conv(9999, nb);
    tick;
    run_conv(12000, nb);
    tick;
    check("sat_bcd", int'(bcd), 16'h9999);
    check("sat_ovf", int'(ovf), 1);
    run_conv(7, nb);
    tick;
    check("after_sat_ovf", int'(ovf), 0);
    run_conv(16383, nb);
    tick;

    // Start during busy is ignored.
    bin   = 14'd42;
    start = 1'b1;
    tick;
    exp_q.push_back(ref_model(42));
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    repeat (4) tick;
    bin   = 14'd555;
    start = 1'b1;
    tick;
    start = 1'b0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      tick;
    end
    check("ignored_start_len", nb, 9);
    repeat (3) tick;
    check("no_second_conv", int'(busy), 0);
    check("ignored_bcd", int'(bcd), 16'h0042);

    // Reset in the middle of a conversion.
    bin   = 14'd808;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (6) tick;
    check("busy_before_rst", int'(busy), 1);
    rst = 1'b0;
    tick;
    check("midrst_bcd",  int'(bcd),  0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    rst = 1'b1;
    repeat (20) tick;
    run_conv(61, nb);
    tick;
    check("post_rst_bcd", int'(bcd), 16'h0061);

    // Start held high: one acceptance every 15 cycles; bin scrambled while busy.
    start = 1'b1;
    for (int i = 0; i < 120; i++) begin
      int v;
      if (i % 3 == 0) v = i * 84;
      else if (i % 7 == 0) v = $urandom_range(9990, 16383);
      else v = $urandom_range(0, 9999);
      bin = 14'(v);
      tick;
      exp_q.push_back(ref_model(v));
      repeat (14) begin
        bin = 14'($urandom_range(0, 16383));
        tick;
      end
      check("b2b_done_period", int'(done), 1);
    end
    start = 1'b0;
    repeat (20) tick;
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if something wedges the stimulus.
  initial begin
    #500000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 4-digit seven-segment multiplexer and drives its 16-bit packed BCD `num` input.
- Converts a binary count (0..9999) into four BCD digits on a start/done handshake.
- Holds the last result steady so the display never shows intermediate values.

Parameters:
- BIN_W, 14: width of the binary input in bits.
- DIGITS, 4: number of BCD output digits; output width is 4*DIGITS.
- MAX_VAL, 9999: largest value representable; larger inputs saturate to this value.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- bin  input  BIN_W  binary value to convert; sampled only when a start is accepted.
- start  input  1  conversion request; level-sampled.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd has been updated.
- bcd  output  4*DIGITS  packed BCD result; digit 0 is in [3:0], digit 3 in [15:12].
- ovf  output  1  set when the last converted input exceeded MAX_VAL.

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - bcd=0, busy=0, done=0, ovf=0; shift register and bit counter are cleared.
  - Reset mid-conversion aborts the conversion; no done pulse is produced for it.
- FSM states:
  - IDLE: waiting for start.
  - SHIFT: one input bit processed per cycle.
- IDLE to SHIFT, on an edge where start==1:
  - Load the working register {bcd_acc = 0, bin_reg = sat(bin)}.
  - sat(x) = MAX_VAL if x > MAX_VAL, else x; record ovf_pending = (x > MAX_VAL).
  - Set cnt=0 and busy=1.
- SHIFT, each cycle:
  - Add 3 to every 4-bit digit of bcd_acc that is >= 5.
  - Then shift the concatenation {bcd_acc, bin_reg} left by 1.
  - Increment cnt.
- SHIFT to IDLE, on the edge where cnt == BIN_W-1:
  - The final corrected shift result is written to the bcd output register, and ovf <= ovf_pending.
  - done is high for exactly the following cycle; busy goes low in the same cycle.
- Latency: start sampled at edge E0 gives bcd/done valid after edge E0+BIN_W, i.e. 14 cycles of busy.
- bcd and ovf change only on completion or reset and hold between conversions. Intermediate accumulator values never reach bcd.
- start while busy==1 is ignored; no queuing and no effect on the running conversion.
- start held high continuously: a new conversion is accepted in the IDLE cycle in which done is high (back-to-back throughput of one result per BIN_W+1 cycles).
- bin may change freely while busy; only the value at the accepting edge matters.
- Arithmetic: the accumulator is 4*DIGITS bits wide. The add-3 correction never carries across a digit boundary for inputs <= MAX_VAL, and saturation guarantees this.
- No combinational path from any input to any output; all outputs are registers.

Decomposition:
- Shared package:
  - BIN_W, DIGITS, and MAX_VAL defaults.
  - FSM state encoding (IDLE=0, SHIFT=1).
  - Counter width: clog2(BIN_W).
- The same constants are reused by the seven-segment multiplexer for its `num` width.
- One natural sub-module: bcd_digit_adj, a combinational 4-bit "if >=5 add 3" corrector, instantiated DIGITS times inside the shift datapath.

Test Plan:
- Reset, then bin=0, start pulse → busy for 14 cycles; done pulse; bcd=16'h0000, ovf=0.
- bin=1234, start pulse → after 14 busy cycles bcd=16'h1234, done high for exactly 1 cycle, ovf=0; bcd still 16'h1234 20 cycles later.
- bin=9999 → bcd=16'h9999, ovf=0. bin=12000 → bcd=16'h9999, ovf=1. A following bin=7 → bcd=16'h0007, ovf=0.
- bin=42 started; start pulsed again with bin=555 at cycle 5 of busy → result bcd=16'h0042; only one done pulse.
- bin=808 started; rst=0 at cycle 7 of busy → next cycle bcd=0, busy=0, done=0, and no done pulse follows; after release, a conversion of 61 gives bcd=16'h0061.
- start held high with bin sweeping 0..9999 → each done shows the BCD of the value sampled at its accepting edge; period 15 cycles; compared against a reference model.
